// File: rtl/mux_pipe_nto1.sv
// N-to-1 selector feeding a DEPTH-stage register pipeline that carries
// valid and select-error tags, with stall (hold) and flush (invalidate).

module mux_pipe_stage #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    input  logic             e_i,
    output logic [WIDTH-1:0] d_o,
    output logic             v_o,
    output logic             e_o
);
    logic [WIDTH-1:0] d_q;
    logic             v_q;
    logic             e_q;

    // Flush wins over stall and only kills the tags; data is left in place.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= '0;
            v_q <= 1'b0;
            e_q <= 1'b0;
        end else if (flush_i) begin
            v_q <= 1'b0;
            e_q <= 1'b0;
        end else if (!stall_i) begin
            d_q <= d_i;
            v_q <= v_i;
            e_q <= e_i;
        end
    end

    assign d_o = d_q;
    assign v_o = v_q;
    assign e_o = e_q;
endmodule

module mux_pipe_nto1 #(
    parameter int               WIDTH       = 5,
    parameter int               NUM_IN      = 4,
    parameter int               SEL_W       = 2,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    localparam int              OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [WIDTH*NUM_IN-1:0] in_bus_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    in_valid_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic [WIDTH-1:0]        out_o,
    output logic                    out_valid_o,
    output logic                    sel_err_o,
    output logic [OCC_W-1:0]        occupancy_o
);
    logic [WIDTH-1:0]             cap_d;
    logic                         cap_e;
    logic [DEPTH-1:0][WIDTH-1:0]  dat_pipe;
    logic [DEPTH-1:0]             vld_pipe;
    logic [DEPTH-1:0]             err_pipe;
    logic [OCC_W-1:0]             occ;

    // The index compare uses every sel bit, so unused codes fall through
    // to the default/error path instead of aliasing onto a real input.
    always_comb begin
        cap_d = DEFAULT_VAL;
        cap_e = in_valid_i;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_i == SEL_W'(i)) begin
                cap_d = in_bus_i[i*WIDTH +: WIDTH];
                cap_e = 1'b0;
            end
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;
        logic             e_in;

        if (s == 0) begin : g_head
            assign d_in = cap_d;
            assign v_in = in_valid_i;
            assign e_in = cap_e;
        end else begin : g_body
            assign d_in = dat_pipe[s-1];
            assign v_in = vld_pipe[s-1];
            assign e_in = err_pipe[s-1];
        end

        mux_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .stall_i (stall_i),
            .d_i     (d_in),
            .v_i     (v_in),
            .e_i     (e_in),
            .d_o     (dat_pipe[s]),
            .v_o     (vld_pipe[s]),
            .e_o     (err_pipe[s])
        );
    end

    always_comb begin
        occ = '0;
        for (int s = 0; s < DEPTH; s++) begin
            occ = occ + OCC_W'(vld_pipe[s]);
        end
    end

    assign out_o       = dat_pipe[DEPTH-1];
    assign out_valid_o = vld_pipe[DEPTH-1];
    assign sel_err_o   = err_pipe[DEPTH-1];
    assign occupancy_o = occ;
endmodule

// File: tb/tb_mux_pipe_nto1.sv
// Scoreboard bench for mux_pipe_nto1: directed vectors push expected words,
// a negedge monitor pops and compares whenever a new valid word emerges.

module tb_mux_pipe_nto1;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] in_bus;
    logic [1:0]  sel;
    logic        in_valid, stall, flush;
    logic [4:0]  out;
    logic        out_valid, sel_err;
    logic [1:0]  occ;

    logic [14:0] in_bus2;
    logic [1:0]  sel2;
    logic        in_valid2;
    logic [4:0]  out2;
    logic        out_valid2, sel_err2;
    logic [1:0]  occ2;

    int tests = 0;
    int fails = 0;
    logic [4:0] pend_d;
    logic [4:0] sb[$];
    logic       adv_seen = 1'b0;

    always #5 clk = ~clk;

    mux_pipe_nto1 u_dut (
        .clk_i(clk), .rst_ni(rst_n), .in_bus_i(in_bus), .sel_i(sel),
        .in_valid_i(in_valid), .stall_i(stall), .flush_i(flush),
        .out_o(out), .out_valid_o(out_valid), .sel_err_o(sel_err),
        .occupancy_o(occ)
    );

    mux_pipe_nto1 #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .DEPTH(2),
                    .DEFAULT_VAL(5'd30)) u_oor (
        .clk_i(clk), .rst_ni(rst_n), .in_bus_i(in_bus2), .sel_i(sel2),
        .in_valid_i(in_valid2), .stall_i(1'b0), .flush_i(1'b0),
        .out_o(out2), .out_valid_o(out_valid2), .sel_err_o(sel_err2),
        .occupancy_o(occ2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: present one input word for the next rising edge.
    task automatic drive(input logic [1:0] s, input logic v, input logic st,
                         input logic fl, input logic [4:0] ed);
        sel = s; in_valid = v; stall = st; flush = fl; pend_d = ed;
        @(negedge clk);
    endtask

    // Scoreboard feed: only words actually accepted by stage 0 are expected.
    always @(posedge clk) begin
        adv_seen <= rst_n && !flush && !stall;
        if (!rst_n || flush) sb.delete();
        else if (!stall && in_valid) sb.push_back(pend_d);
    end

    always @(negedge clk) begin
        if (rst_n && adv_seen && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {27'd0, out}, 32'hFFFF_FFFF);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                chk("sb_data", {27'd0, out}, {27'd0, e});
                chk("sb_err", {31'd0, sel_err}, 32'd0);
            end
        end
    end

    initial begin
        in_bus  = {5'd7, 5'd3, 5'd31, 5'd9};
        in_bus2 = {5'd3, 5'd31, 5'd9};
        rst_n = 1'b0; sel = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        sel2 = '0; in_valid2 = 1'b0; pend_d = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", {27'd0, out}, 0);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_err", {31'd0, sel_err}, 0);
        chk("rst_occ", {30'd0, occ}, 0);
        rst_n = 1'b1;

        // Single word, sel=1 -> 31 after two edges; occupancy 1,1,0
        drive(2'd1, 1'b1, 1'b0, 1'b0, 5'd31);
        chk("basic_occ1", {30'd0, occ}, 1);
        chk("basic_early", {31'd0, out_valid}, 0);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("basic_occ2", {30'd0, occ}, 1);
        chk("basic_out", {27'd0, out}, 31);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("basic_occ3", {30'd0, occ}, 0);
        chk("basic_valid_off", {31'd0, out_valid}, 0);

        // Streaming all four inputs back to back
        drive(2'd0, 1'b1, 1'b0, 1'b0, 5'd9);
        drive(2'd1, 1'b1, 1'b0, 1'b0, 5'd31);
        chk("stream_occ_a", {30'd0, occ}, 2);
        drive(2'd2, 1'b1, 1'b0, 1'b0, 5'd3);
        chk("stream_occ_b", {30'd0, occ}, 2);
        drive(2'd3, 1'b1, 1'b0, 1'b0, 5'd7);
        chk("stream_occ_c", {30'd0, occ}, 2);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("stream_drained", {30'd0, occ}, 0);

        // Stall with 9 at the output and 3 behind it
        drive(2'd0, 1'b1, 1'b0, 1'b0, 5'd9);
        drive(2'd2, 1'b1, 1'b0, 1'b0, 5'd3);
        for (int i = 0; i < 3; i++) begin
            drive(2'd3, 1'b1, 1'b1, 1'b0, 5'd7);
            chk("stall_out", {27'd0, out}, 9);
            chk("stall_valid", {31'd0, out_valid}, 1);
            chk("stall_occ", {30'd0, occ}, 2);
        end
        drive(2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("stall_release", {27'd0, out}, 3);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Flush together with stall on a full pipeline
        drive(2'd1, 1'b1, 1'b0, 1'b0, 5'd31);
        drive(2'd3, 1'b1, 1'b0, 1'b0, 5'd7);
        drive(2'd0, 1'b1, 1'b1, 1'b1, 5'd9);
        chk("flush_valid", {31'd0, out_valid}, 0);
        chk("flush_occ", {30'd0, occ}, 0);
        chk("flush_data_held", {27'd0, out}, 31);
        drive(2'd2, 1'b1, 1'b0, 1'b0, 5'd3);
        chk("flush_occ_after", {30'd0, occ}, 1);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("flush_next_word", {27'd0, out}, 3);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Asynchronous reset with the pipeline full
        drive(2'd0, 1'b1, 1'b0, 1'b0, 5'd9);
        drive(2'd1, 1'b1, 1'b0, 1'b0, 5'd31);
        chk("prerst_occ", {30'd0, occ}, 2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", {27'd0, out}, 0);
        chk("arst_valid", {31'd0, out_valid}, 0);
        chk("arst_err", {31'd0, sel_err}, 0);
        chk("arst_occ", {30'd0, occ}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'd3, 1'b1, 1'b0, 1'b0, 5'd7);
        chk("rel_occ", {30'd0, occ}, 1);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("rel_out", {27'd0, out}, 7);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Out-of-range select on the 3-input instance
        sel2 = 2'd3; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("oor_out", {27'd0, out2}, 30);
        chk("oor_err", {31'd0, sel_err2}, 1);
        chk("oor_valid", {31'd0, out_valid2}, 1);
        @(negedge clk);
        chk("oor_inv_err", {31'd0, sel_err2}, 0);
        chk("oor_inv_valid", {31'd0, out_valid2}, 0);
        chk("oor_inv_out", {27'd0, out2}, 30);
        sel2 = 2'd2; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("inr_out", {27'd0, out2}, 3);
        chk("inr_err", {31'd0, sel_err2}, 0);
        chk("inr_valid", {31'd0, out_valid2}, 1);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
